gemm_store_controller: RTL and testbench
========================================

// Module: gemm_store_controller
// PURPOSE
// - Store stage of GEMM control. It sits next to the load/execute FSM and runs once per result tile.
// - While can_store is high, it writes msize accumulator rows of the C tile to memory, nsize words per row.
// - Its *_store outputs go through the load/execute muxes to the shared memory interface and the address generator.
// - It pulses done_store in the cycle the last row write commits.
// PARAMETERS
// - ADDR_W  32  width of addresses and strides
// - SIZE_W  5   width of msize/nsize and of the row counter
// PORTS
// - clk                     in   1       clock, all logic on posedge
// - rst                     in   1       synchronous reset, active-low (0 = reset)
// - can_store               in   1       level; high while load/execute grants the interface for storing
// - tile_C_addr             in   ADDR_W  byte address of C row 0; sampled at store start
// - tile_C_stride           in   ADDR_W  byte distance between C rows; sampled at store start
// - msize                   in   SIZE_W  rows to write; sampled at store start
// - nsize                   in   SIZE_W  words per row; sampled at store start
// - mem_ready               in   1       interface accepts the write presented this cycle
// - gen_addr_store          out  1       load next_row_addr_store into the address generator
// - next_row_addr_store     out  ADDR_W  address to generate
// - interface_en_store      out  1       write request valid
// - interface_rdwr_store    out  1       1 = write; equals interface_en_store
// - interface_control_store out  SIZE_W  words per request (latched nsize)
// - acc_rd_en               out  1       read accumulator row acc_rd_row (data due next cycle)
// - acc_rd_row              out  SIZE_W  accumulator row index
// - done_store              out  1       one-cycle pulse: last row committed
// BEHAVIOUR
// - Outputs are Mealy/combinational from state, counters and inputs, so the load/execute FSM can mux them the same cycle.
// - While rst=0 and after the next edge: state=IDLE, row_cnt=0, all regs 0, all outputs 0.
// - States: IDLE, WRITE, EMPTY.
// - IDLE, can_store=0: all outputs 0.
// - IDLE, can_store=1, msize!=0 (start):
//   - gen_addr_store=1, next_row_addr_store=tile_C_addr, acc_rd_en=1, acc_rd_row=0.
//   - Latch tile_C_addr->row_addr, tile_C_stride, msize, nsize; row_cnt<=0; ns=WRITE.
// - IDLE, can_store=1, msize==0: latch sizes, ns=EMPTY, no requests.
// - EMPTY: done_store=1, interface_en_store=0, ns=IDLE.
// - WRITE:
//   - interface_en_store=interface_rdwr_store=1, interface_control_store=nsize_q.
//   - Write commits when mem_ready=1.
//   - Commit, row_cnt!=msize_q-1:
//     - row_cnt++, row_addr<=row_addr+stride_q (mod 2^ADDR_W, no saturation).
//     - gen_addr_store=1, next_row_addr_store=row_addr+stride_q.
//     - acc_rd_en=1, acc_rd_row=row_cnt+1.
//   - Commit, row_cnt==msize_q-1: done_store=1, no gen_addr/acc_rd, ns=IDLE.
//   - mem_ready=0: hold request and all registers; gen_addr_store=0, acc_rd_en=0.
// - Latency: msize rows take msize cycles with mem_ready held high. Start cycle to done_store = msize cycles.
// - can_store falls in WRITE/EMPTY: abort, ns=IDLE, no done_store, outputs 0 that cycle. An uncommitted row is dropped.
// - can_store high in IDLE right after done_store: treated as a new start (back-to-back tiles allowed).
// - Inputs changing mid-store are ignored; latched copies are used.
// - rst=0 mid-WRITE: IDLE at the next edge; no done_store.
// CONFIGURATION
// - `STORE_ACC_CLR_EN` defined: adds output acc_clr (1 bit, reset 0).
//   - acc_clr pulses high the cycle after done_store, clearing the accumulators for the next tile.
//   - No pulse on abort.
// - `STORE_ACC_CLR_EN` undefined: port and logic absent. Accumulators are cleared by the load/execute path (we_accum_ctrl).
// TESTING
// - msize=4, nsize=8, C=0x1000, stride=0x40, mem_ready=1:
//   - gen addrs 0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles.
//   - 4 write cycles, control=8; done_store at write 4.
// - Same config, mem_ready=0 on cycles 2-3 of WRITE:
//   - Request held at 0x1040; completes in 6 cycles; addresses unchanged.
// - msize=0:
//   - No interface_en_store; done_store 1 cycle after start.
// - msize=3, can_store dropped after first commit:
//   - IDLE, no done_store; restart writes from tile_C_addr again.
// - rst=0 during WRITE row 2 of 4:
//   - All outputs 0 next cycle; IDLE; a fresh store completes normally.
// - Back-to-back tiles: can_store high across two tiles, stride 0xFFFFFFC0 (wrap):
//   - Addresses decrement mod 2^32; two done_store pulses.
//   - With STORE_ACC_CLR_EN: acc_clr one cycle after each done_store.

Source files
------------

// File: rtl/gemm_store_controller.sv
// GEMM store stage: writes msize accumulator rows of the C tile, nsize words per row, while can_store is granted.
// Optional STORE_ACC_CLR_EN adds acc_clr, pulsed the cycle after done_store.
module gemm_store_controller #(
   parameter int ADDR_W = 32,
   parameter int SIZE_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              can_store,
   input  logic [ADDR_W-1:0] tile_C_addr,
   input  logic [ADDR_W-1:0] tile_C_stride,
   input  logic [SIZE_W-1:0] msize,
   input  logic [SIZE_W-1:0] nsize,
   input  logic              mem_ready,
   output logic              gen_addr_store,
   output logic [ADDR_W-1:0] next_row_addr_store,
   output logic              interface_en_store,
   output logic              interface_rdwr_store,
   output logic [SIZE_W-1:0] interface_control_store,
   output logic              acc_rd_en,
   output logic [SIZE_W-1:0] acc_rd_row,
`ifdef STORE_ACC_CLR_EN
   output logic              acc_clr,
`endif
   output logic              done_store
);

   // state | meaning
   // IDLE  | waiting for can_store; start cycle issues row 0 address and accumulator read
   // WRITE | write request for row row_cnt_q presented until mem_ready commits it
   // EMPTY | zero-row tile, report done_store without any request
   typedef enum logic [1:0] {IDLE, WRITE, EMPTY} state_e;

   state_e            state_q, state_d;
   logic [SIZE_W-1:0] row_cnt_q, row_cnt_d;
   logic [ADDR_W-1:0] row_addr_q, row_addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [SIZE_W-1:0] msize_q, msize_d;
   logic [SIZE_W-1:0] nsize_q, nsize_d;
   logic [ADDR_W-1:0] row_addr_nxt;
   logic              last_row;

   assign row_addr_nxt = row_addr_q + stride_q;
   assign last_row     = (row_cnt_q == msize_q - SIZE_W'(1));

   always_comb begin
      state_d                 = state_q;
      row_cnt_d               = row_cnt_q;
      row_addr_d              = row_addr_q;
      stride_d                = stride_q;
      msize_d                 = msize_q;
      nsize_d                 = nsize_q;
      gen_addr_store          = 1'b0;
      next_row_addr_store     = '0;
      interface_en_store      = 1'b0;
      interface_control_store = '0;
      acc_rd_en               = 1'b0;
      acc_rd_row              = '0;
      done_store              = 1'b0;
      case (state_q)
         IDLE: begin
            if (can_store) begin
               row_addr_d = tile_C_addr;
               stride_d   = tile_C_stride;
               msize_d    = msize;
               nsize_d    = nsize;
               row_cnt_d  = '0;
               if (msize != '0) begin
                  gen_addr_store      = 1'b1;
                  next_row_addr_store = tile_C_addr;
                  acc_rd_en           = 1'b1;
                  state_d             = WRITE;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         WRITE: begin
            if (!can_store) begin
               // grant withdrawn: the uncommitted row is dropped
               state_d   = IDLE;
               row_cnt_d = '0;
            end else begin
               interface_en_store      = 1'b1;
               interface_control_store = nsize_q;
               if (mem_ready) begin
                  if (last_row) begin
                     done_store = 1'b1;
                     state_d    = IDLE;
                     row_cnt_d  = '0;
                  end else begin
                     row_cnt_d           = row_cnt_q + SIZE_W'(1);
                     row_addr_d          = row_addr_nxt;
                     gen_addr_store      = 1'b1;
                     next_row_addr_store = row_addr_nxt;
                     acc_rd_en           = 1'b1;
                     acc_rd_row          = row_cnt_q + SIZE_W'(1);
                  end
               end
            end
         end
         EMPTY: begin
            state_d    = IDLE;
            done_store = can_store;
         end
         default: state_d = IDLE;
      endcase
      // outputs are held quiet for the whole reset cycle
      if (!rst) begin
         gen_addr_store          = 1'b0;
         next_row_addr_store     = '0;
         interface_en_store      = 1'b0;
         interface_control_store = '0;
         acc_rd_en               = 1'b0;
         acc_rd_row              = '0;
         done_store              = 1'b0;
      end
   end

   assign interface_rdwr_store = interface_en_store;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         row_cnt_q  <= '0;
         row_addr_q <= '0;
         stride_q   <= '0;
         msize_q    <= '0;
         nsize_q    <= '0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         row_addr_q <= row_addr_d;
         stride_q   <= stride_d;
         msize_q    <= msize_d;
         nsize_q    <= nsize_d;
      end
   end

`ifdef STORE_ACC_CLR_EN
   logic acc_clr_q;

   always_ff @(posedge clk) begin
      if (!rst) acc_clr_q <= 1'b0;
      else      acc_clr_q <= done_store;
   end

   assign acc_clr = acc_clr_q;
`endif

endmodule

// File: tb/tb_gemm_store_controller.sv
// Directed bench for gemm_store_controller; checks every output each cycle against hand-derived values.
// Build with STORE_ACC_CLR_EN defined to also check acc_clr.
module tb_gemm_store_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        can_store;
   logic [31:0] tile_C_addr;
   logic [31:0] tile_C_stride;
   logic [4:0]  msize;
   logic [4:0]  nsize;
   logic        mem_ready;
   logic        gen_addr_store;
   logic [31:0] next_row_addr_store;
   logic        interface_en_store;
   logic        interface_rdwr_store;
   logic [4:0]  interface_control_store;
   logic        acc_rd_en;
   logic [4:0]  acc_rd_row;
   logic        done_store;
`ifdef STORE_ACC_CLR_EN
   logic        acc_clr;
   logic        exp_clr = 1'b0;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   string phase = "reset";

   always #5 clk = ~clk;

   gemm_store_controller #(.ADDR_W(32), .SIZE_W(5)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .can_store               (can_store),
      .tile_C_addr             (tile_C_addr),
      .tile_C_stride           (tile_C_stride),
      .msize                   (msize),
      .nsize                   (nsize),
      .mem_ready               (mem_ready),
      .gen_addr_store          (gen_addr_store),
      .next_row_addr_store     (next_row_addr_store),
      .interface_en_store      (interface_en_store),
      .interface_rdwr_store    (interface_rdwr_store),
      .interface_control_store (interface_control_store),
      .acc_rd_en               (acc_rd_en),
      .acc_rd_row              (acc_rd_row),
`ifdef STORE_ACC_CLR_EN
      .acc_clr                 (acc_clr),
`endif
      .done_store              (done_store)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s.%s: got 0x%0h expected 0x%0h (t=%0t)", phase, tag, obs, exp_v, $time);
   endtask

   task automatic drive(input logic cs, input logic mr, input logic [4:0] m, input logic [4:0] n,
                        input logic [31:0] c, input logic [31:0] s);
      can_store     = cs;
      mem_ready     = mr;
      msize         = m;
      nsize         = n;
      tile_C_addr   = c;
      tile_C_stride = s;
   endtask

   // check all outputs mid-cycle, then advance to just after the next edge
   task automatic step(input logic e_gen, input logic [31:0] e_addr, input logic e_en,
                       input logic [4:0] e_ctl, input logic e_rd, input logic [4:0] e_row,
                       input logic e_done);
      @(negedge clk);
      chk("gen_addr",  32'(gen_addr_store),          32'(e_gen));
      chk("addr",      next_row_addr_store,          e_addr);
      chk("en",        32'(interface_en_store),      32'(e_en));
      chk("rdwr",      32'(interface_rdwr_store),    32'(e_en));
      chk("control",   32'(interface_control_store), 32'(e_ctl));
      chk("acc_rd_en", 32'(acc_rd_en),               32'(e_rd));
      chk("acc_row",   32'(acc_rd_row),              32'(e_row));
      chk("done",      32'(done_store),              32'(e_done));
`ifdef STORE_ACC_CLR_EN
      chk("acc_clr",   32'(acc_clr),                 32'(exp_clr));
      exp_clr = rst ? e_done : 1'b0;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      step(0, 32'h0, 0, 5'd0, 0, 5'd0, 0);
   endtask

   initial begin
      rst = 1'b0;
      drive(1, 1, 5'd4, 5'd8, 32'h1000, 32'h40);
      @(posedge clk); #1;
      @(posedge clk); #1;
      idle_step();                       // start request ignored while in reset
      rst = 1'b1;

      phase = "basic";                   // msize=4 nsize=8, inputs changed after start
      step(1, 32'h1000, 0, 5'd0, 1, 5'd0, 0);
      drive(1, 1, 5'd9, 5'd2, 32'hDEAD0000, 32'h4);
      step(1, 32'h1040, 1, 5'd8, 1, 5'd1, 0);
      step(1, 32'h1080, 1, 5'd8, 1, 5'd2, 0);
      step(1, 32'h10C0, 1, 5'd8, 1, 5'd3, 0);
      step(0, 32'h0,    1, 5'd8, 0, 5'd0, 1);
      drive(0, 1, 5'd4, 5'd8, 32'h1000, 32'h40);
      idle_step();

      phase = "stall";                   // mem_ready low on WRITE cycles 2-3
      drive(1, 1, 5'd4, 5'd8, 32'h1000, 32'h40);
      step(1, 32'h1000, 0, 5'd0, 1, 5'd0, 0);
      step(1, 32'h1040, 1, 5'd8, 1, 5'd1, 0);
      mem_ready = 1'b0;
      step(0, 32'h0, 1, 5'd8, 0, 5'd0, 0);
      step(0, 32'h0, 1, 5'd8, 0, 5'd0, 0);
      mem_ready = 1'b1;
      step(1, 32'h1080, 1, 5'd8, 1, 5'd2, 0);
      step(1, 32'h10C0, 1, 5'd8, 1, 5'd3, 0);
      step(0, 32'h0,    1, 5'd8, 0, 5'd0, 1);
      can_store = 1'b0;
      idle_step();

      phase = "empty";                   // msize=0
      drive(1, 1, 5'd0, 5'd8, 32'h3000, 32'h40);
      idle_step();
      step(0, 32'h0, 0, 5'd0, 0, 5'd0, 1);
      can_store = 1'b0;
      idle_step();

      phase = "abort";                   // msize=3, grant dropped after first commit
      drive(1, 1, 5'd3, 5'd4, 32'h2000, 32'h10);
      step(1, 32'h2000, 0, 5'd0, 1, 5'd0, 0);
      step(1, 32'h2010, 1, 5'd4, 1, 5'd1, 0);
      can_store = 1'b0;
      idle_step();
      idle_step();
      can_store = 1'b1;
      step(1, 32'h2000, 0, 5'd0, 1, 5'd0, 0);
      step(1, 32'h2010, 1, 5'd4, 1, 5'd1, 0);
      step(1, 32'h2020, 1, 5'd4, 1, 5'd2, 0);
      step(0, 32'h0,    1, 5'd4, 0, 5'd0, 1);
      can_store = 1'b0;
      idle_step();

      phase = "reset_mid";               // reset while writing row 2 of 4
      drive(1, 1, 5'd4, 5'd8, 32'h1000, 32'h40);
      step(1, 32'h1000, 0, 5'd0, 1, 5'd0, 0);
      step(1, 32'h1040, 1, 5'd8, 1, 5'd1, 0);
      rst = 1'b0;
      idle_step();
      rst = 1'b1;
      can_store = 1'b0;
      idle_step();
      drive(1, 1, 5'd2, 5'd6, 32'h500, 32'h8);
      step(1, 32'h500, 0, 5'd0, 1, 5'd0, 0);
      step(1, 32'h508, 1, 5'd6, 1, 5'd1, 0);
      step(0, 32'h0,   1, 5'd6, 0, 5'd0, 1);
      can_store = 1'b0;
      idle_step();

      phase = "b2b_wrap";                // two tiles back to back, negative stride
      drive(1, 1, 5'd2, 5'd3, 32'h100, 32'hFFFFFFC0);
      step(1, 32'h100, 0, 5'd0, 1, 5'd0, 0);
      step(1, 32'h0C0, 1, 5'd3, 1, 5'd1, 0);
      tile_C_addr = 32'h20;
      step(0, 32'h0,   1, 5'd3, 0, 5'd0, 1);
      step(1, 32'h20,  0, 5'd0, 1, 5'd0, 0);
      step(1, 32'hFFFFFFE0, 1, 5'd3, 1, 5'd1, 0);
      step(0, 32'h0,   1, 5'd3, 0, 5'd0, 1);
      can_store = 1'b0;
      idle_step();
      idle_step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
